button_conditioner: RTL and testbench
=====================================

# button_conditioner

Upstream input stage for the reaction-timer top level. Takes the raw, active-low, bouncing push-buttons from the board and turns them into clean, synchronised, active-high events for the control FSM:
- a debounced `pressed` level;
- single-cycle `press_pulse` and `release_pulse`;
- a one-shot `long_pulse` per press, usable for reset-by-hold.

Each button runs its own debounce FSM, timed by a shared millisecond prescaler in the `Clk` domain.

## Interface
Parameters:
- `N_BTN`, 2: number of buttons handled.
- `TICK_DIV`, 50000: `Clk` cycles per 1 ms tick; must be ≥ 2.
- `DEBOUNCE_MS`, 20: stable ticks required to accept a press or a release; must be ≥ 1.
- `LONG_MS`, 1000: ticks in HELD before `long_pulse` fires; must be ≥ 1.

Ports:
- `Clk`, in, 1: system clock. All logic runs on its rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `button`, in, `N_BTN`: raw board buttons, active-low, asynchronous to `Clk`.
- `pressed`, out, `N_BTN`: debounced state; 1 means held.
- `press_pulse`, out, `N_BTN`: one-cycle strobe when a press is accepted.
- `release_pulse`, out, `N_BTN`: one-cycle strobe when a release is accepted.
- `long_pulse`, out, `N_BTN`: one-cycle strobe, at most once per press.

## Operation
**Reset**
- All outputs are 0, all FSMs are in IDLE, all counters are 0, the prescaler is 0.
- Synchroniser flops reset to 1 (released).

**Synchroniser and prescaler**
- Each `button` bit passes through a 2-flop synchroniser; `s` is the synchronised value.
- The prescaler counts 0..`TICK_DIV`-1 and wraps. `tick` = 1 in the cycle where the prescaler equals `TICK_DIV`-1.
- The prescaler free-runs and is shared by all buttons.

**Per-button FSM**
- IDLE
  - `pressed` = 0.
  - If `s` = 0: go to ARM and clear `deb_cnt`.
- ARM
  - If `s` = 1: return to IDLE (bounce). This check has priority over `tick`.
  - Else, on `tick`: `deb_cnt`++.
  - When `tick` arrives with `deb_cnt` = `DEBOUNCE_MS`-1: go to HELD, clear `hold_cnt`, clear `long_done`.
- HELD
  - `pressed` = 1.
  - On `tick`: `hold_cnt`++, saturating at `LONG_MS`.
  - When `tick` arrives with `hold_cnt` = `LONG_MS`-1 and `long_done` = 0: fire `long_pulse` and set `long_done`.
  - If `s` = 1: go to DISARM and clear `deb_cnt`. `hold_cnt` and `long_done` are kept.
- DISARM
  - `pressed` stays 1; `hold_cnt` is frozen.
  - If `s` = 0: return to HELD with no pulse.
  - Else, on `tick` with `deb_cnt` = `DEBOUNCE_MS`-1: go to IDLE.

**Pulses and independence**
- `press_pulse` fires on entry to HELD from ARM only.
- `release_pulse` fires on entry to IDLE from DISARM only.
- Buttons are fully independent. Simultaneous events on different buttons each produce their own pulses in the same cycle.

## Timing
- All outputs are registered.
- `pressed` changes in the same cycle as the corresponding pulse.
- Press latency, from the raw falling edge to `press_pulse`:
  - 2 synchroniser cycles, plus 1 cycle to enter ARM;
  - then `DEBOUNCE_MS` ticks, the first of which may be a partial period.
  - Bound: between (`DEBOUNCE_MS`-1)·`TICK_DIV`+3 and `DEBOUNCE_MS`·`TICK_DIV`+3 cycles.
- Release latency follows the same bound.
- `long_pulse` fires exactly `LONG_MS` ticks after `press_pulse`, counting only time spent in HELD.
- After reset release, the first `tick` occurs on cycle `TICK_DIV`.
- Asserting `reset_n` mid-press forces all outputs to 0 immediately, with no `release_pulse`.
- Pulse widths are always exactly 1 cycle, with no back-to-back repeats within a single press.

## Structure
- Shared package `btn_pkg` holds the 2-bit state encoding constants: IDLE = 0, ARM = 1, HELD = 2, DISARM = 3.
- Sub-module `debounce_fsm`, one per button, instantiated `N_BTN` times in a generate loop.
  - Ports: `Clk`, `reset_n`, `s`, `tick`, and the four outputs.
  - Counter widths: `$clog2(DEBOUNCE_MS+1)` for `deb_cnt` and `$clog2(LONG_MS+1)` for `hold_cnt`.
- The synchronisers and the prescaler live in `button_conditioner`.

## Test plan
Bench parameters: `TICK_DIV`=4, `DEBOUNCE_MS`=3, `LONG_MS`=8.
- **Reset values:** hold `reset_n` low for 3 cycles with `button`=2'b11 → all outputs 0; the first tick occurs on cycle 4 after release.
- **Clean press:** drive `button[0]` low and hold → exactly one `press_pulse[0]`, 11–15 cycles after the edge; `pressed[0]`=1; `button[1]` outputs stay 0.
- **Bounce rejection:** toggle `button[0]` every 5 cycles for 40 cycles, then release → no pulses and `pressed` stays 0 throughout.
- **Long press:** keep holding after the press → exactly one `long_pulse[0]` 32 cycles after `press_pulse[0]`; no second pulse after 100 more cycles.
- **Release with glitch:** release, glitch low for 2 cycles, then release cleanly → exactly one `release_pulse[0]`; `pressed[0]` falls in the same cycle; no extra `press_pulse`.
- **Async reset mid-press:** both buttons in HELD, `reset_n` asserted mid-cycle → `pressed`=0 before the next `Clk` edge; no `release_pulse` is ever emitted.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioning path.
// The state encoding is fixed so the control side can decode it if exposed later.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    HELD   = 2'd2,
    DISARM = 2'd3
  } btn_state_t;

endpackage

// File: rtl/debounce_fsm.sv
// Per-button debounce FSM: accepts a press/release after DEBOUNCE_MS stable ticks
// and emits one-cycle press, release and long-hold strobes.
module debounce_fsm
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000
) (
  input  logic Clk,
  input  logic reset_n,
  input  logic s,
  input  logic tick,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int DW = $clog2(DEBOUNCE_MS + 1);
  localparam int HW = $clog2(LONG_MS + 1);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_MS - 1);
  localparam logic [DW-1:0] DEB_ONE   = DW'(1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_MS - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_MS);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

  btn_state_t    state;
  logic [DW-1:0] deb_cnt;
  logic [HW-1:0] hold_cnt;
  logic          long_done;

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      deb_cnt       <= '0;
      hold_cnt      <= '0;
      long_done     <= 1'b0;
      pressed       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      case (state)
        IDLE: begin
          pressed <= 1'b0;
          if (!s) begin
            state   <= ARM;
            deb_cnt <= '0;
          end
        end
        ARM: begin
          // A bounce back to released wins over a coincident tick.
          if (s) begin
            state <= IDLE;
          end else if (tick) begin
            if (deb_cnt == DEB_LAST) begin
              state       <= HELD;
              hold_cnt    <= '0;
              long_done   <= 1'b0;
              pressed     <= 1'b1;
              press_pulse <= 1'b1;
            end else begin
              deb_cnt <= deb_cnt + DEB_ONE;
            end
          end
        end
        HELD: begin
          pressed <= 1'b1;
          if (tick) begin
            if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + HOLD_ONE;
            if (hold_cnt == HOLD_LAST && !long_done) begin
              long_pulse <= 1'b1;
              long_done  <= 1'b1;
            end
          end
          if (s) begin
            state   <= DISARM;
            deb_cnt <= '0;
          end
        end
        DISARM: begin
          // hold_cnt and long_done survive a release glitch.
          if (!s) begin
            state <= HELD;
          end else if (tick) begin
            if (deb_cnt == DEB_LAST) begin
              state         <= IDLE;
              pressed       <= 1'b0;
              release_pulse <= 1'b1;
            end else begin
              deb_cnt <= deb_cnt + DEB_ONE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Input stage for raw active-low board buttons: 2-flop synchronisers, a shared
// millisecond prescaler and one debounce FSM per button.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN       = 2,
  parameter int TICK_DIV    = 50000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000
) (
  input  logic             Clk,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] button,
  output logic [N_BTN-1:0] pressed,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] long_pulse
);

  localparam int PW = $clog2(TICK_DIV);

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);

  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] sync2;
  logic [PW-1:0]    presc;
  logic             tick;

  // Synchronisers reset to the released level so no false press follows reset.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PRESC_ONE;
    end
  end

  assign tick = (presc == PRESC_LAST);

  generate
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
      debounce_fsm #(
        .DEBOUNCE_MS(DEBOUNCE_MS),
        .LONG_MS    (LONG_MS)
      ) u_fsm (
        .Clk          (Clk),
        .reset_n      (reset_n),
        .s            (sync2[gi]),
        .tick         (tick),
        .pressed      (pressed[gi]),
        .press_pulse  (press_pulse[gi]),
        .release_pulse(release_pulse[gi]),
        .long_pulse   (long_pulse[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with TICK_DIV=4, DEBOUNCE_MS=3, LONG_MS=8.
module tb_button_conditioner;

  logic       Clk = 1'b0;
  logic       reset_n;
  logic [1:0] button;
  logic [1:0] pressed;
  logic [1:0] press_pulse;
  logic [1:0] release_pulse;
  logic [1:0] long_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  int press_cnt[2]   = '{0, 0};
  int release_cnt[2] = '{0, 0};
  int long_cnt[2]    = '{0, 0};
  int width_err      = 0;
  logic [1:0] prev_pp = 2'b00;
  logic [1:0] prev_rp = 2'b00;
  logic [1:0] prev_lp = 2'b00;

  button_conditioner #(
    .N_BTN      (2),
    .TICK_DIV   (4),
    .DEBOUNCE_MS(3),
    .LONG_MS    (8)
  ) dut (
    .Clk          (Clk),
    .reset_n      (reset_n),
    .button       (button),
    .pressed      (pressed),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse)
  );

  always #5 Clk = ~Clk;

  // Pulse counters and back-to-back detector, sampled mid-cycle.
  always @(negedge Clk) begin
    for (int i = 0; i < 2; i++) begin
      if (press_pulse[i] === 1'b1)   press_cnt[i]++;
      if (release_pulse[i] === 1'b1) release_cnt[i]++;
      if (long_pulse[i] === 1'b1)    long_cnt[i]++;
    end
    if (((press_pulse & prev_pp) | (release_pulse & prev_rp) | (long_pulse & prev_lp)) !== 2'b00)
      width_err++;
    prev_pp = press_pulse;
    prev_rp = release_pulse;
    prev_lp = long_pulse;
  end

  task automatic test_reset();
    reset_n = 1'b0;
    button  = 2'b11;
    for (int c = 0; c < 3; c++) begin
      @(posedge Clk); #1;
      n_checks++;
      if ({pressed, press_pulse, release_pulse, long_pulse} !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d: got %b want 00000000", c,
                 {pressed, press_pulse, release_pulse, long_pulse});
      end
    end
    $display("reset: outputs=%b", {pressed, press_pulse, release_pulse, long_pulse});
    reset_n = 1'b1;
  endtask

  // Press starts in the same step as reset release, so the first tick (edge 4)
  // fixes the exact latency: ARM at edge 3, ticks at 4, 8, 12.
  task automatic test_clean_press();
    int n = 0;
    bit seen = 0;
    int side_err = 0;
    button[0] = 1'b0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(posedge Clk); #1;
      if (pressed[1] !== 1'b0 || press_pulse[1] !== 1'b0) side_err++;
      if (press_pulse[0] === 1'b1) begin
        seen = 1;
        n = k;
      end else if (pressed[0] !== 1'b0) begin
        side_err++;
      end
    end
    $display("clean_press: seen=%0d latency=%0d pressed=%b", seen, n, pressed);
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL press_seen: got no press_pulse[0] within 20 cycles, want one");
    end
    n_checks++;
    if (n != 12) begin
      n_fail++;
      $display("FAIL press_latency: got %0d want 12", n);
    end
    n_checks++;
    if (pressed[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL press_level: got %b want 1", pressed[0]);
    end
    n_checks++;
    if (side_err != 0) begin
      n_fail++;
      $display("FAIL press_side_effects: got %0d bad cycles want 0", side_err);
    end
  endtask

  task automatic test_long_press();
    int m = 0;
    bit seen = 0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(posedge Clk); #1;
      if (k == 1) begin
        n_checks++;
        if (press_pulse[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL press_width: got %b want 0 one cycle after pulse", press_pulse[0]);
        end
      end
      if (long_pulse[0] === 1'b1) begin
        seen = 1;
        m = k;
      end
    end
    $display("long_press: seen=%0d cycles_after_press=%0d", seen, m);
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL long_seen: got no long_pulse[0] within 40 cycles, want one");
    end
    n_checks++;
    if (m != 32) begin
      n_fail++;
      $display("FAIL long_latency: got %0d want 32", m);
    end
    @(posedge Clk); #1;
    n_checks++;
    if (long_pulse[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL long_width: got %b want 0", long_pulse[0]);
    end
    repeat (100) @(posedge Clk);
    #1;
    $display("long_hold: long_cnt=%0d press_cnt=%0d", long_cnt[0], press_cnt[0]);
    n_checks++;
    if (long_cnt[0] != 1) begin
      n_fail++;
      $display("FAIL long_once: got %0d want 1", long_cnt[0]);
    end
    n_checks++;
    if (press_cnt[0] != 1) begin
      n_fail++;
      $display("FAIL long_press_count: got %0d want 1", press_cnt[0]);
    end
  endtask

  task automatic test_release_glitch();
    int lvl_err = 0;
    int n = 0;
    bit seen = 0;
    logic prev_pressed;
    button[0] = 1'b1;
    repeat (5) begin
      @(posedge Clk); #1;
      if (pressed[0] !== 1'b1 || release_pulse[0] !== 1'b0) lvl_err++;
    end
    button[0] = 1'b0;
    repeat (2) begin
      @(posedge Clk); #1;
      if (pressed[0] !== 1'b1 || release_pulse[0] !== 1'b0) lvl_err++;
    end
    button[0] = 1'b1;
    prev_pressed = pressed[0];
    for (int k = 1; k <= 30 && !seen; k++) begin
      @(posedge Clk); #1;
      if (release_pulse[0] === 1'b1) begin
        seen = 1;
        n = k;
      end else begin
        prev_pressed = pressed[0];
      end
    end
    $display("release_glitch: seen=%0d latency=%0d pressed=%b", seen, n, pressed);
    n_checks++;
    if (lvl_err != 0 || prev_pressed !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_hold: got %0d bad cycles (last pressed=%b) want 0 (1)", lvl_err, prev_pressed);
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL release_seen: got no release_pulse[0] within 30 cycles, want one");
    end
    n_checks++;
    if (n < 11 || n > 15) begin
      n_fail++;
      $display("FAIL release_latency: got %0d want 11..15", n);
    end
    n_checks++;
    if (pressed[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL release_level: got %b want 0 with pulse", pressed[0]);
    end
    repeat (5) @(posedge Clk);
    #1;
    n_checks++;
    if (release_cnt[0] != 1) begin
      n_fail++;
      $display("FAIL release_count: got %0d want 1", release_cnt[0]);
    end
    n_checks++;
    if (press_cnt[0] != 1) begin
      n_fail++;
      $display("FAIL release_no_repress: got %0d presses want 1", press_cnt[0]);
    end
  endtask

  task automatic test_bounce();
    int err = 0;
    for (int seg = 0; seg < 8; seg++) begin
      button[0] = (seg % 2 == 0) ? 1'b0 : 1'b1;
      repeat (5) begin
        @(posedge Clk); #1;
        if (pressed[0] !== 1'b0 || press_pulse[0] !== 1'b0) err++;
      end
    end
    button[0] = 1'b1;
    repeat (20) begin
      @(posedge Clk); #1;
      if (pressed[0] !== 1'b0 || press_pulse[0] !== 1'b0) err++;
    end
    $display("bounce: bad_cycles=%0d press_cnt=%0d release_cnt=%0d", err, press_cnt[0], release_cnt[0]);
    n_checks++;
    if (err != 0) begin
      n_fail++;
      $display("FAIL bounce_level: got %0d bad cycles want 0", err);
    end
    n_checks++;
    if (press_cnt[0] != 1) begin
      n_fail++;
      $display("FAIL bounce_press_count: got %0d want 1", press_cnt[0]);
    end
    n_checks++;
    if (release_cnt[0] != 1) begin
      n_fail++;
      $display("FAIL bounce_release_count: got %0d want 1", release_cnt[0]);
    end
  endtask

  task automatic test_async_reset();
    bit both = 0;
    button = 2'b00;
    for (int k = 1; k <= 20 && !both; k++) begin
      @(posedge Clk); #1;
      if (press_pulse === 2'b11) both = 1;
    end
    repeat (3) @(posedge Clk);
    #1;
    $display("dual_press: simultaneous=%0d pressed=%b", both, pressed);
    n_checks++;
    if (!both) begin
      n_fail++;
      $display("FAIL dual_press_pulse: got no 2'b11 press_pulse within 20 cycles, want one");
    end
    n_checks++;
    if (pressed !== 2'b11) begin
      n_fail++;
      $display("FAIL dual_pressed: got %b want 11", pressed);
    end
    @(negedge Clk);
    #2;
    reset_n = 1'b0;
    #1;
    $display("async_reset: outputs=%b", {pressed, press_pulse, release_pulse, long_pulse});
    n_checks++;
    if ({pressed, press_pulse, release_pulse, long_pulse} !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset_outputs: got %b want 00000000",
               {pressed, press_pulse, release_pulse, long_pulse});
    end
    button = 2'b11;
    repeat (3) @(posedge Clk);
    #1;
    reset_n = 1'b1;
    repeat (40) @(posedge Clk);
    #1;
    $display("post_reset: pressed=%b release_cnt=%0d,%0d", pressed, release_cnt[0], release_cnt[1]);
    n_checks++;
    if (release_cnt[0] != 1 || release_cnt[1] != 0) begin
      n_fail++;
      $display("FAIL reset_no_release: got %0d,%0d want 1,0", release_cnt[0], release_cnt[1]);
    end
    n_checks++;
    if (pressed !== 2'b00) begin
      n_fail++;
      $display("FAIL post_reset_pressed: got %b want 00", pressed);
    end
  endtask

  task automatic test_pulse_width();
    $display("pulse_width: back_to_back=%0d", width_err);
    n_checks++;
    if (width_err != 0) begin
      n_fail++;
      $display("FAIL pulse_width: got %0d back-to-back pulses want 0", width_err);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    button  = 2'b11;
    test_reset();
    test_clean_press();
    test_long_press();
    test_release_glitch();
    test_bounce();
    test_async_reset();
    test_pulse_width();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
